// File: rtl/frame_rw_scheduler_pkg.sv
// Shared types and defaults for the SDRAM read/write frame scheduler.
package frame_rw_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    localparam int DEF_BURST_LEN   = 64;
    localparam int DEF_FRAME_WORDS = 786432;
    localparam int CMD_LEN_W       = 9;

endpackage

// File: rtl/frame_rw_scheduler_if.sv
// Burst command channel between the frame scheduler and the SDRAM controller.
interface frame_rw_scheduler_if #(
    parameter int ADDR_W = 24
);
    import frame_rw_scheduler_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [CMD_LEN_W-1:0] cmd_len;
    logic                 burst_done;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready, burst_done
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready, burst_done
    );

endinterface

// File: rtl/frame_rw_scheduler_frame_addr_gen.sv
// Per-stream frame offset counter: burst advance, frame wrap and deferred frame sync.
module frame_rw_scheduler_frame_addr_gen #(
    parameter int OFF_W        = 23,
    parameter int BURST_LEN    = 64,
    parameter int FRAME_WORDS  = 786432,
    parameter bit BANK_ON_WRAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             busy,
    input  logic             advance,
    input  logic             sync,
    output logic [OFF_W-1:0] offset,
    output logic             bank_update
);

    localparam logic [OFF_W-1:0] STEP = OFF_W'(BURST_LEN);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(FRAME_WORDS - BURST_LEN);

    logic             sync_pend;
    logic             wrap;
    logic             sync_apply;
    logic [OFF_W-1:0] next_offset;

    // A sync seen while this stream owns a burst waits for burst_done; it then
    // zeroes the offset after the advance, so a same-cycle wrap still counts.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        wrap        = advance && (offset == LAST);
        sync_apply  = advance ? (sync_pend || sync) : (sync && !busy);
        next_offset = offset;
        if (advance) begin
            next_offset = wrap ? '0 : offset + STEP;
        end
        if (sync_apply) begin
            next_offset = '0;
        end
    end

    assign bank_update = BANK_ON_WRAP ? wrap : sync_apply;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments only.
        if (!rst_n) begin
            offset    <= '0;
            sync_pend <= 1'b0;
        end else begin
            offset    <= next_offset;
            sync_pend <= advance ? 1'b0 : (sync_pend || (sync && busy));
        end
    end

endmodule

// File: rtl/frame_rw_scheduler.sv
// Arbitrates the SDRAM command port between capture writes and display reads,
// with ping-pong frame banks so display always reads the last complete frame.
module frame_rw_scheduler
    import frame_rw_scheduler_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int USEDW_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic [USEDW_W-1:0]   wr_usedw,
    input  logic                 rd_req,
    input  logic                 wr_frame_sync,
    input  logic                 rd_frame_sync,
    frame_rw_scheduler_if.master cmd,
    output logic                 wr_bank,
    output logic                 rd_bank,
    output logic                 frame_valid
);

    localparam int OFF_W = ADDR_W - 1;

    state_t            state;
    state_t            next_state;
    grant_t            last_grant;
    logic              grant_valid;
    logic              grant_wr;
    logic              wr_pend;
    logic              rd_pend;
    logic              cmd_write_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic              in_burst;
    logic              wr_busy;
    logic              rd_busy;
    logic              wr_advance;
    logic              rd_advance;
    logic [OFF_W-1:0]  wr_offset;
    logic [OFF_W-1:0]  rd_offset;
    logic              wr_wrap;
    logic              rd_load;
    logic              done_bank;

    assign wr_pend = int'(wr_usedw) >= BURST_LEN;
    assign rd_pend = rd_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ties go to the stream that did not win the previous accepted command.
    always_comb begin
        next_state  = state;
        grant_valid = 1'b0;
        grant_wr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (init_done) next_state = ST_ARB;
            end
            ST_ARB: begin
                if (!init_done) begin
                    next_state = ST_IDLE;
                end else if (wr_pend || rd_pend) begin
                    grant_valid = 1'b1;
                    grant_wr    = wr_pend && (!rd_pend || last_grant == GRANT_RD);
                    next_state  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd.cmd_ready) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (cmd.burst_done) next_state = ST_ARB;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A stream counts as busy from its grant cycle until its burst_done.
    assign in_burst   = (state == ST_ISSUE) || (state == ST_WAIT);
    assign wr_busy    = (grant_valid && grant_wr) || (in_burst && cmd_write_q);
    assign rd_busy    = (grant_valid && !grant_wr) || (in_burst && !cmd_write_q);
    assign wr_advance = (state == ST_WAIT) && cmd.burst_done && cmd_write_q;
    assign rd_advance = (state == ST_WAIT) && cmd.burst_done && !cmd_write_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            last_grant  <= GRANT_WR;
        end else begin
            if (grant_valid) begin
                cmd_write_q <= grant_wr;
                cmd_addr_q  <= grant_wr ? {wr_bank, wr_offset} : {rd_bank, rd_offset};
            end
            if (state == ST_ISSUE && cmd.cmd_ready) begin
                last_grant <= cmd_write_q ? GRANT_WR : GRANT_RD;
            end
        end
    end

    assign cmd.cmd_valid = (state == ST_ISSUE);
    assign cmd.cmd_write = cmd_write_q;
    assign cmd.cmd_addr  = cmd_addr_q;
    assign cmd.cmd_len   = CMD_LEN_W'(BURST_LEN);

    frame_rw_scheduler_frame_addr_gen #(
        .OFF_W        (OFF_W),
        .BURST_LEN    (BURST_LEN),
        .FRAME_WORDS  (FRAME_WORDS),
        .BANK_ON_WRAP (1'b1)
    ) u_wr_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .busy        (wr_busy),
        .advance     (wr_advance),
        .sync        (wr_frame_sync),
        .offset      (wr_offset),
        .bank_update (wr_wrap)
    );

    frame_rw_scheduler_frame_addr_gen #(
        .OFF_W        (OFF_W),
        .BURST_LEN    (BURST_LEN),
        .FRAME_WORDS  (FRAME_WORDS),
        .BANK_ON_WRAP (1'b0)
    ) u_rd_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .busy        (rd_busy),
        .advance     (rd_advance),
        .sync        (rd_frame_sync),
        .offset      (rd_offset),
        .bank_update (rd_load)
    );

    // A finished write frame becomes the bank the display switches to on its next sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            done_bank   <= 1'b1;
            frame_valid <= 1'b0;
        end else begin
            if (wr_wrap) begin
                done_bank   <= wr_bank;
                wr_bank     <= ~wr_bank;
                frame_valid <= 1'b1;
            end
            if (rd_load) begin
                rd_bank <= done_bank;
            end
        end
    end

endmodule

// File: tb/tb_frame_rw_scheduler.sv
// Self-checking bench for frame_rw_scheduler: directed scenarios plus a random
// run against a transaction-level model of offsets, banks and arbitration.
module tb_frame_rw_scheduler;

    localparam int BL = 64;
    localparam int FW = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_done;
    logic [9:0] wr_usedw;
    logic       rd_req;
    logic       wr_frame_sync;
    logic       rd_frame_sync;
    logic       wr_bank;
    logic       rd_bank;
    logic       frame_valid;

    int checks = 0;
    int errors = 0;

    // Model state: index 1 = write stream, index 0 = read stream.
    int m_off  [2];
    bit m_bank [2];
    bit m_pend [2];
    bit m_done;
    bit m_fv;
    bit m_last_wr;

    frame_rw_scheduler_if #(.ADDR_W(24)) ifc ();

    frame_rw_scheduler #(
        .ADDR_W      (24),
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW),
        .USEDW_W     (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_done     (init_done),
        .wr_usedw      (wr_usedw),
        .rd_req        (rd_req),
        .wr_frame_sync (wr_frame_sync),
        .rd_frame_sync (rd_frame_sync),
        .cmd           (ifc),
        .wr_bank       (wr_bank),
        .rd_bank       (rd_bank),
        .frame_valid   (frame_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_reset();
        m_off[0] = 0; m_off[1] = 0;
        m_bank[0] = 1'b1; m_bank[1] = 1'b0;
        m_pend[0] = 1'b0; m_pend[1] = 1'b0;
        m_done = 1'b1; m_fv = 1'b0; m_last_wr = 1'b1;
    endfunction

    function automatic void model_apply_sync(input int s);
        m_off[s] = 0;
        if (s == 0) m_bank[0] = m_done;
    endfunction

    function automatic void model_done(input int s);
        m_off[s] += BL;
        if (m_off[s] == FW) begin
            m_off[s] = 0;
            if (s == 1) begin
                m_done = m_bank[1];
                m_bank[1] = !m_bank[1];
                m_fv = 1'b1;
            end
        end
        if (m_pend[s]) begin
            m_pend[s] = 1'b0;
            model_apply_sync(s);
        end
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0; init_done = 1'b0; wr_usedw = '0; rd_req = 1'b0;
        wr_frame_sync = 1'b0; rd_frame_sync = 1'b0;
        ifc.cmd_ready = 1'b0; ifc.burst_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Controller stand-in: waits for a command, stalls ready for 'hold' cycles,
    // accepts, optionally pulses frame syncs during WAIT, then pulses burst_done.
    task automatic do_burst(input int hold, input int lat, input bit sw, input bit sr,
                            input bit drop_init, output bit w, output logic [23:0] a);
        int n;
        n = 0;
        while (ifc.cmd_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        w = ifc.cmd_write;
        a = ifc.cmd_addr;
        checks++;
        if (ifc.cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL cmd_timeout: cmd_valid=%b after %0d cycles, required 1", ifc.cmd_valid, n);
            return;
        end
        if (drop_init) init_done = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (ifc.cmd_valid !== 1'b1 || ifc.cmd_write !== w || ifc.cmd_addr !== a) begin
                errors++;
                $display("FAIL hold_stable: stall %0d valid=%b write=%b addr=%h, required 1/%b/%h", i, ifc.cmd_valid, ifc.cmd_write, ifc.cmd_addr, w, a);
            end
        end
        ifc.cmd_ready = 1'b1;
        @(negedge clk);
        ifc.cmd_ready = 1'b0;
        checks++;
        if (ifc.cmd_valid !== 1'b0) begin errors++; $display("FAIL accept_drop: cmd_valid=%b after accept, required 0", ifc.cmd_valid); end
        for (int i = 0; i < lat; i++) begin
            if (i == 0) begin wr_frame_sync = sw; rd_frame_sync = sr; end
            @(negedge clk);
            wr_frame_sync = 1'b0; rd_frame_sync = 1'b0;
        end
        ifc.burst_done = 1'b1;
        @(negedge clk);
        ifc.burst_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        wr_usedw = 10'd64; rd_req = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (ifc.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b, required 0", ifc.cmd_valid); end
        checks++; if (ifc.cmd_write !== 1'b0) begin errors++; $display("FAIL reset_cmd_write: got %b, required 0", ifc.cmd_write); end
        checks++; if (ifc.cmd_addr !== 24'h0) begin errors++; $display("FAIL reset_cmd_addr: got %h, required 000000", ifc.cmd_addr); end
        checks++; if (ifc.cmd_len !== 9'd64) begin errors++; $display("FAIL reset_cmd_len: got %0d, required 64", ifc.cmd_len); end
        checks++; if (wr_bank !== 1'b0) begin errors++; $display("FAIL reset_wr_bank: got %b, required 0", wr_bank); end
        checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL reset_rd_bank: got %b, required 1", rd_bank); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b, required 0", frame_valid); end
    endtask

    task automatic test_first_write();
        bit w; logic [23:0] a;
        reset_dut();
        init_done = 1'b1; wr_usedw = 10'd64;
        do_burst(0, 2, 1'b0, 1'b0, 1'b0, w, a);
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL first_write_dir: got %b, required 1", w); end
        checks++; if (a !== 24'h000000) begin errors++; $display("FAIL first_write_addr: got %h, required 000000", a); end
        do_burst(0, 2, 1'b0, 1'b0, 1'b0, w, a);
        checks++; if (a !== 24'h000040) begin errors++; $display("FAIL second_write_addr: got %h, required 000040", a); end
    endtask

    task automatic test_alternate();
        bit w; logic [23:0] a;
        bit          ew [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [23:0] ea [4] = '{24'h800000, 24'h000000, 24'h800040, 24'h000040};
        reset_dut();
        init_done = 1'b1; wr_usedw = 10'd100; rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_burst(0, 1 + i, 1'b0, 1'b0, 1'b0, w, a);
            checks++; if (w !== ew[i] || a !== ea[i]) begin errors++; $display("FAIL alternate_%0d: got write=%b addr=%h, required write=%b addr=%h", i, w, a, ew[i], ea[i]); end
            checks++; if (ifc.cmd_valid !== 1'b0) begin errors++; $display("FAIL alternate_gap_%0d: cmd_valid=%b one cycle after burst_done, required 0", i, ifc.cmd_valid); end
            @(negedge clk);
            checks++; if (ifc.cmd_valid !== 1'b1) begin errors++; $display("FAIL alternate_latency_%0d: cmd_valid=%b two cycles after burst_done, required 1", i, ifc.cmd_valid); end
        end
    endtask

    task automatic test_backpressure();
        bit w; logic [23:0] a;
        reset_dut();
        init_done = 1'b1; wr_usedw = 10'd64;
        do_burst(5, 2, 1'b0, 1'b0, 1'b0, w, a);
        checks++; if (w !== 1'b1 || a !== 24'h000000) begin errors++; $display("FAIL stall_cmd: got write=%b addr=%h, required write=1 addr=000000", w, a); end
        do_burst(0, 1, 1'b0, 1'b0, 1'b0, w, a);
        checks++; if (a !== 24'h000040) begin errors++; $display("FAIL stall_single_accept: next addr %h, required 000040", a); end
    endtask

    task automatic test_frame_wrap();
        bit w; logic [23:0] a;
        reset_dut();
        init_done = 1'b1; wr_usedw = 10'd64;
        for (int i = 0; i < 4; i++) begin
            do_burst(0, 1, 1'b0, 1'b0, 1'b0, w, a);
            checks++; if (a !== 24'(i * BL)) begin errors++; $display("FAIL wrap_write_%0d: got addr %h, required %h", i, a, 24'(i * BL)); end
        end
        wr_usedw = 10'd0;
        checks++; if (wr_bank !== 1'b1 || frame_valid !== 1'b1 || rd_bank !== 1'b1) begin errors++; $display("FAIL wrap_banks: wr_bank=%b frame_valid=%b rd_bank=%b, required 1/1/1", wr_bank, frame_valid, rd_bank); end
        rd_frame_sync = 1'b1;
        @(negedge clk);
        rd_frame_sync = 1'b0;
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL wrap_rd_sync_bank: got %b, required 0", rd_bank); end
        rd_req = 1'b1;
        do_burst(0, 1, 1'b0, 1'b0, 1'b0, w, a);
        checks++; if (w !== 1'b0 || a !== 24'h000000) begin errors++; $display("FAIL wrap_read: got write=%b addr=%h, required write=0 addr=000000", w, a); end
        rd_req = 1'b0; wr_usedw = 10'd64;
        do_burst(0, 1, 1'b0, 1'b0, 1'b0, w, a);
        checks++; if (w !== 1'b1 || a !== 24'h800000) begin errors++; $display("FAIL wrap_next_write: got write=%b addr=%h, required write=1 addr=800000", w, a); end
    endtask

    task automatic test_sync_in_wait();
        bit w; logic [23:0] a;
        logic [23:0] ea  [8] = '{24'h0, 24'h40, 24'h80, 24'h0, 24'h40, 24'h80, 24'hC0, 24'h800000};
        bit          esw [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        reset_dut();
        init_done = 1'b1; wr_usedw = 10'd64;
        for (int i = 0; i < 8; i++) begin
            do_burst(0, 2, esw[i], 1'b0, 1'b0, w, a);
            checks++; if (a !== ea[i]) begin errors++; $display("FAIL sync_write_%0d: got addr %h, required %h", i, a, ea[i]); end
            if (i == 2) begin
                checks++; if (wr_bank !== 1'b0) begin errors++; $display("FAIL sync_keeps_bank: wr_bank=%b, required 0", wr_bank); end
            end
        end
        checks++; if (wr_bank !== 1'b1 || frame_valid !== 1'b1) begin errors++; $display("FAIL sync_with_wrap: wr_bank=%b frame_valid=%b, required 1/1", wr_bank, frame_valid); end
    endtask

    task automatic test_init_drop();
        bit w; logic [23:0] a;
        int seen;
        reset_dut();
        init_done = 1'b1; wr_usedw = 10'd64;
        do_burst(0, 2, 1'b0, 1'b0, 1'b1, w, a);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifc.cmd_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL init_drop_idle: cmd_valid high %0d cycles, required 0", seen); end
        init_done = 1'b1;
        do_burst(0, 1, 1'b0, 1'b0, 1'b0, w, a);
        checks++; if (a !== 24'h000040) begin errors++; $display("FAIL init_drop_resume: got addr %h, required 000040", a); end
    endtask

    task automatic test_reset_mid_burst();
        bit w; logic [23:0] a;
        int n;
        int seen;
        reset_dut();
        init_done = 1'b1; wr_usedw = 10'd64;
        for (int i = 0; i < 4; i++) do_burst(0, 1, 1'b0, 1'b0, 1'b0, w, a);
        rd_frame_sync = 1'b1;
        @(negedge clk);
        rd_frame_sync = 1'b0;
        n = 0;
        while (ifc.cmd_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (ifc.cmd_valid !== 1'b1 || rd_bank !== 1'b0) begin errors++; $display("FAIL midreset_setup: cmd_valid=%b rd_bank=%b, required 1/0", ifc.cmd_valid, rd_bank); end
        ifc.cmd_ready = 1'b1;
        @(negedge clk);
        ifc.cmd_ready = 1'b0;
        rst_n = 1'b0; init_done = 1'b0;
        #1;
        checks++; if (ifc.cmd_valid !== 1'b0 || ifc.cmd_addr !== 24'h0) begin errors++; $display("FAIL midreset_cmd: cmd_valid=%b cmd_addr=%h, required 0/000000", ifc.cmd_valid, ifc.cmd_addr); end
        checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b1 || frame_valid !== 1'b0) begin errors++; $display("FAIL midreset_banks: wr_bank=%b rd_bank=%b frame_valid=%b, required 0/1/0", wr_bank, rd_bank, frame_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ifc.cmd_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_idle: cmd_valid high %0d cycles without init_done, required 0", seen); end
        init_done = 1'b1;
        do_burst(0, 1, 1'b0, 1'b0, 1'b0, w, a);
        checks++; if (w !== 1'b1 || a !== 24'h000000) begin errors++; $display("FAIL midreset_restart: got write=%b addr=%h, required write=1 addr=000000", w, a); end
    endtask

    task automatic test_random();
        bit w; logic [23:0] a;
        bit ew; logic [23:0] ea;
        bit sw, sr;
        reset_dut();
        model_reset();
        init_done = 1'b1;
        for (int it = 0; it < 80; it++) begin
            wr_usedw = 10'($urandom_range(0, 127));
            rd_req   = 1'($urandom_range(0, 1));
            if (wr_usedw < 10'd64 && !rd_req) rd_req = 1'b1;
            ew = (wr_usedw >= 10'd64 && rd_req) ? !m_last_wr : (wr_usedw >= 10'd64);
            m_last_wr = ew;
            ea = {m_bank[ew], 23'(m_off[ew])};
            sw = ($urandom_range(0, 4) == 0);
            sr = ($urandom_range(0, 4) == 0);
            do_burst(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), sw, sr, 1'b0, w, a);
            checks++; if (w !== ew || a !== ea) begin errors++; $display("FAIL random_cmd_%0d: got write=%b addr=%h, required write=%b addr=%h", it, w, a, ew, ea); end
            if (sw) begin if (ew) m_pend[1] = 1'b1; else model_apply_sync(1); end
            if (sr) begin if (!ew) m_pend[0] = 1'b1; else model_apply_sync(0); end
            model_done(int'(ew));
            checks++; if (wr_bank !== m_bank[1] || rd_bank !== m_bank[0] || frame_valid !== m_fv) begin errors++; $display("FAIL random_banks_%0d: wr_bank=%b rd_bank=%b frame_valid=%b, required %b/%b/%b", it, wr_bank, rd_bank, frame_valid, m_bank[1], m_bank[0], m_fv); end
        end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_alternate();
        test_backpressure();
        test_frame_wrap();
        test_sync_in_wait();
        test_init_drop();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_rw_scheduler.md
# frame_rw_scheduler

Schedules the single SDRAM command port between the camera capture write stream and the VGA display read stream. Issues fixed-length burst commands, generates per-stream frame addresses and manages two frame banks (ping-pong) so the display always reads the last completed frame. Sits between the capture/display FIFOs and the SDRAM controller.

## Interface
- ADDR_W, 24, command address width; MSB is bank select, lower ADDR_W-1 bits are word offset
- BURST_LEN, 64, words per burst; power of two, ≤ 256
- FRAME_WORDS, 786432, words per frame (1024×768); multiple of BURST_LEN, < 2^(ADDR_W-1)
- USEDW_W, 10, width of capture FIFO fill level

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- init_done  in  1  SDRAM controller initialisation complete, level
- wr_usedw  in  USEDW_W  capture FIFO fill level
- rd_req  in  1  display FIFO refill request, level with hysteresis
- wr_frame_sync  in  1  camera frame start, 1-cycle pulse
- rd_frame_sync  in  1  display frame start, 1-cycle pulse
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  controller accepts command when cmd_valid & cmd_ready
- cmd_write  out  1  1 = write burst, 0 = read burst
- cmd_addr  out  ADDR_W  {bank, offset} start address
- cmd_len  out  9  burst length, constant BURST_LEN
- burst_done  in  1  1-cycle pulse, last word of accepted burst transferred
- wr_bank  out  1  bank being written
- rd_bank  out  1  bank being displayed
- frame_valid  out  1  at least one complete frame written since reset

## Operation
- FSM states: IDLE, ARB, ISSUE, WAIT.
- IDLE: stay until init_done=1, then ARB.
- ARB: wr_pend = wr_usedw ≥ BURST_LEN; rd_pend = rd_req. Only one pending → grant it. Both → grant opposite of last_grant (last_grant resets to write, so first tie goes to read). Neither → stay in ARB. Grant → ISSUE, latch cmd_write/cmd_addr.
- ISSUE: cmd_valid=1, all cmd_* fields held stable; on cmd_valid & cmd_ready → WAIT, update last_grant.
- WAIT: on burst_done → advance granted stream offset by BURST_LEN, apply deferred syncs, → ARB.
- Write offset reaching FRAME_WORDS: offset←0, done_bank←wr_bank, wr_bank toggles, frame_valid←1 (sticky).
- Read offset reaching FRAME_WORDS: offset←0, rd_bank unchanged.
- wr_frame_sync: wr offset←0, bank unchanged (partial frame discarded). rd_frame_sync: rd offset←0, rd_bank←done_bank.
- Sync arriving while the affected stream has a burst in ISSUE/WAIT: recorded in a pending flag, applied in the burst_done cycle, after the offset advance (sync overrides wrap offset; a wrap in the same cycle still toggles bank first).
- Sync in any other state applies next cycle. Second sync before application is merged.
- init_done falling: finish current burst, then return to IDLE from ARB.
- burst_done outside WAIT is ignored.

## Timing
- Reset values: cmd_valid 0, cmd_write 0, cmd_addr 0, cmd_len BURST_LEN, wr_bank 0, rd_bank 1, done_bank 1, frame_valid 0, both offsets 0, state IDLE.
- ARB decision to cmd_valid rise: 1 cycle. Accept to WAIT: 1 cycle.
- burst_done to next cmd_valid: 2 cycles minimum (WAIT→ARB→ISSUE).
- Reset mid-burst: all state returns to reset values immediately; controller is reset by the same rst_n.

## Structure
- Shared package: state enum, grant encoding (GRANT_RD/GRANT_WR), default BURST_LEN and FRAME_WORDS constants.
- One sub-module natural: frame_addr_gen (offset counter, wrap, deferred-sync flag), instantiated twice (write, read); bank logic stays in top.

## Test plan
- Reset release, init_done=1, wr_usedw=64, rd_req=0, cmd_ready=1 → first cmd: write, addr 0x000000, len 64; after burst_done next write addr 0x000040.
- wr_usedw=100 and rd_req=1 held, cmd_ready=1 → commands alternate R,W,R,W starting with read; cmd_addr read 0x800000, 0x800040 (rd_bank=1).
- cmd_ready low 5 cycles during ISSUE → cmd_valid, cmd_addr, cmd_write stable all 5 cycles; exactly one command accepted.
- FRAME_WORDS=256 override: 4 write bursts → wr_bank 0→1, frame_valid=1; rd_frame_sync → rd_bank=0, next read addr 0x000000.
- wr_frame_sync during write WAIT at offset 128 → burst_done advances then zeros offset; next write addr {wr_bank,0}; wr_bank unchanged.
- rst_n low while in WAIT → cmd_valid 0, wr_bank 0, rd_bank 1, frame_valid 0 same cycle; IDLE until init_done.
